// File: rtl/work_dispatch.sv
// work_dispatch: assembles 44-byte host work packets, starts the miner core and returns the golden nonce
// Ports: clk/rst (async active-high); rx_data/rx_valid host bytes in; tx_data/tx_valid/tx_ready nonce bytes out;
//        midstate/data2/start_mining work to the core; miner_busy/got_ticket/golden_nonce from the core; exhausted pulse
module work_dispatch #(
  parameter int          START_GUARD = 4,
  parameter logic [23:0] RX_TIMEOUT  = 24'd1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         start_mining,
  input  logic         miner_busy,
  input  logic         got_ticket,
  input  logic [31:0]  golden_nonce,
  output logic         exhausted
);
  typedef enum logic [2:0] {IDLE, LOAD, START, GUARD, MINING, REPORT} state_t;
  state_t state, state_n;
  logic [351:0] shadow;
  logic [5:0]   cnt;
  logic [23:0]  gap;
  logic         pending, done, pend_n, cap;
  logic [7:0]   gcnt;
  logic [31:0]  nonce;
  logic [1:0]   idx;
  // a packet completing this cycle counts as pending immediately so LOAD follows the last byte directly
  assign done   = rx_valid && cnt == 6'd43;
  assign pend_n = pending | done;
  // bytes shift in from the top so byte k ends up at bits [8k+7:8k] after 44 bytes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow  <= '0;
      cnt     <= '0;
      gap     <= '0;
      pending <= 1'b0;
    end else begin
      if (rx_valid) begin
        shadow <= {rx_data, shadow[351:8]};
        cnt    <= done ? 6'd0 : cnt + 6'd1;
        gap    <= '0;
      end else if (cnt != 6'd0) begin
        gap <= gap + 24'd1;
        if (gap == RX_TIMEOUT - 24'd1) begin
          cnt <= '0;
          gap <= '0;
        end
      end
      pending <= done | (pending & (state != LOAD));
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      midstate <= '0;
      data2    <= '0;
      gcnt     <= '0;
      nonce    <= '0;
      idx      <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD) {data2, midstate} <= shadow;
      gcnt <= (state == GUARD) ? gcnt + 8'd1 : 8'd0;
      if (cap) nonce <= golden_nonce;
      idx <= (state != REPORT) ? 2'd0 : tx_ready ? idx + 2'd1 : idx;
    end
  always_comb begin
    state_n      = state;
    start_mining = 1'b0;
    exhausted    = 1'b0;
    tx_valid     = 1'b0;
    cap          = 1'b0;
    tx_data      = nonce[{idx, 3'b000} +: 8];
    unique case (state)
      IDLE:   state_n = pend_n ? LOAD : IDLE;
      LOAD:   state_n = START;
      START: begin
        start_mining = 1'b1;
        state_n      = GUARD;
      end
      GUARD:  state_n = pend_n ? LOAD : (gcnt == 8'(START_GUARD - 1)) ? MINING : GUARD;
      MINING:
        if (pend_n) state_n = LOAD;
        else if (got_ticket) begin
          cap     = 1'b1;
          state_n = REPORT;
        end else if (!miner_busy) begin
          exhausted = 1'b1;
          state_n   = IDLE;
        end
      REPORT: begin
        tx_valid = 1'b1;
        if (tx_ready && idx == 2'd3) state_n = pend_n ? LOAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_work_dispatch.sv
// tb_work_dispatch: randomized directed checks of work_dispatch against a byte-array reference model
module tb_work_dispatch;
  localparam logic [23:0] TO = 24'd40;
  logic         clk = 1'b0, rst = 1'b1;
  logic [7:0]   rx_data = '0, tx_data;
  logic         rx_valid = 1'b0, tx_valid, tx_ready = 1'b0;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         start_mining, miner_busy = 1'b0, got_ticket = 1'b0, exhausted;
  logic [31:0]  golden_nonce = '0;
  logic [7:0]   pkt [44];
  logic [31:0]  nv;
  int n_chk = 0, n_fail = 0, starts = 0, s0;
  work_dispatch #(.START_GUARD(4), .RX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .midstate(midstate), .data2(data2), .start_mining(start_mining),
    .miner_busy(miner_busy), .got_ticket(got_ticket), .golden_nonce(golden_nonce),
    .exhausted(exhausted)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (start_mining) starts++;
  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [351:0] model_work();
    logic [351:0] r = '0;
    for (int k = 0; k < 44; k++) r[8*k +: 8] = pkt[k];
    return r;
  endfunction
  task automatic rand_pkt();
    for (int k = 0; k < 44; k++) pkt[k] = 8'($urandom);
  endtask
  task automatic send(input int a, input int b);
    for (int k = a; k < b; k++) begin
      @(negedge clk);
      rx_data  = pkt[k];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic chk_start(input logic busy);
    chk("start_early", start_mining, 0);
    @(negedge clk);
    chk("start_pulse", start_mining, 1);
    chk("work", {data2, midstate}, model_work());
    @(negedge clk);
    chk("start_len", start_mining, 0);
    miner_busy = busy;
    got_ticket = 1'b0;
  endtask
  task automatic to_mining();
    repeat (5) @(negedge clk);
  endtask
  task automatic report(input logic [31:0] n, input int mode);
    int i = 0, c = 0;
    logic r;
    while (i < 4 && c < 60) begin
      @(negedge clk);
      chk("tx_valid", tx_valid, 1);
      chk("tx_byte", tx_data, n[8*i +: 8]);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      tx_ready = r;
      if (r) i++;
      c++;
    end
    chk("report_bytes", i, 4);
    if (mode == 0) chk("report_consecutive", c, 4);
    @(negedge clk);
    chk("tx_valid_end", tx_valid, 0);
    tx_ready = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_midstate", midstate, 0);
    chk("rst_data2", data2, 0);
    chk("rst_start", start_mining, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_exhausted", exhausted, 0);
    rst = 1'b0;
    for (int k = 0; k < 44; k++) pkt[k] = 8'(k);
    send(0, 44);
    chk_start(1);
    chk("ms_lo", midstate[7:0], 8'h00);
    chk("ms_hi", midstate[255:248], 8'h1f);
    chk("d2_hi", data2[95:88], 8'h2b);
    to_mining();
    got_ticket = 1'b1;
    golden_nonce = 32'h80001234;
    report(32'h80001234, 0);
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    repeat (3) @(negedge clk);
    rand_pkt();
    send(0, 44);
    chk_start(1);
    to_mining();
    got_ticket = 1'b1;
    report(32'h80001234, 1);
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    repeat (3) @(negedge clk);
    rand_pkt();
    send(0, 44);
    chk_start(1);
    to_mining();
    miner_busy = 1'b0;
    #1;
    chk("exhausted_pulse", exhausted, 1);
    chk("exhausted_no_tx", tx_valid, 0);
    @(negedge clk);
    chk("exhausted_len", exhausted, 0);
    chk("exhausted_idle_tx", tx_valid, 0);
    s0 = starts;
    rand_pkt();
    send(0, 20);
    repeat (int'(TO) + 5) @(negedge clk);
    rand_pkt();
    send(0, 44);
    chk_start(0);
    repeat (8) @(negedge clk);
    chk("timeout_starts", starts - s0, 1);
    rand_pkt();
    send(0, 20);
    repeat (int'(TO) - 10) @(negedge clk);
    send(20, 44);
    chk_start(0);
    repeat (8) @(negedge clk);
    s0 = starts;
    rand_pkt();
    send(0, 44);
    chk_start(1);
    to_mining();
    rand_pkt();
    send(0, 43);
    @(negedge clk);
    rx_data = pkt[43];
    rx_valid = 1'b1;
    got_ticket = 1'b1;
    golden_nonce = $urandom;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("abort_no_tx", tx_valid, 0);
    chk_start(1);
    to_mining();
    chk("abort_ticket_dropped", tx_valid, 0);
    chk("abort_starts", starts - s0, 2);
    miner_busy = 1'b0;
    repeat (3) @(negedge clk);
    rand_pkt();
    send(0, 44);
    chk_start(1);
    to_mining();
    nv = $urandom;
    golden_nonce = nv;
    got_ticket = 1'b1;
    rand_pkt();
    send(0, 44);
    chk("rep_stall_valid", tx_valid, 1);
    chk("rep_stall_byte", tx_data, nv[7:0]);
    chk("rep_no_start", start_mining, 0);
    report(nv, 2);
    @(negedge clk);
    chk("rep_then_start", start_mining, 1);
    chk("rep_then_work", {data2, midstate}, model_work());
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    repeat (8) @(negedge clk);
    rand_pkt();
    send(0, 44);
    chk_start(1);
    to_mining();
    golden_nonce = $urandom;
    got_ticket = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rep_valid_before", tx_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_rep_valid", tx_valid, 0);
    chk("rst_rep_midstate", midstate, 0);
    @(negedge clk);
    rst = 1'b0;
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    @(negedge clk);
    chk("rst_rep_no_resend", tx_valid, 0);
    rand_pkt();
    send(0, 20);
    rst = 1'b1;
    #1;
    chk("rst_pkt_midstate", midstate, 0);
    chk("rst_pkt_data2", data2, 0);
    @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    rand_pkt();
    send(0, 44);
    chk_start(0);
    repeat (8) @(negedge clk);
    chk("rst_pkt_starts", starts - s0, 1);
    for (int r = 0; r < 4; r++) begin
      rand_pkt();
      send(0, 44);
      chk_start(1);
      to_mining();
      nv = $urandom;
      golden_nonce = nv;
      got_ticket = 1'b1;
      report(nv, 2);
      got_ticket = 1'b0;
      miner_busy = 1'b0;
      repeat (3) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/work_dispatch.md
Name: work_dispatch

Overview:
- Upstream feeder for the SHA-256 double-hash miner core.
- Assembles 44-byte work packets from the host byte stream (UART receiver output) into midstate/data2 registers, then pulses start_mining.
- Monitors miner_busy/got_ticket and returns the 4-byte golden nonce to the host byte transmitter.
- New work arriving during mining aborts the current search and restarts the core.

Parameters:
- START_GUARD, 4, cycles after the start_mining pulse during which miner_busy is ignored (core raises busy 3 cycles after start).
- RX_TIMEOUT, 24'd1000000, idle clock cycles between packet bytes before a partial packet is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid, single-cycle strobe; always accepted
- tx_data  out  8  result byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
- midstate  out  256  work midstate to miner core
- data2  out  96  work tail to miner core
- start_mining  out  1  one-cycle start pulse to miner core
- miner_busy  in  1  core searching
- got_ticket  in  1  core found a nonce; held until next start
- golden_nonce  in  32  valid while got_ticket=1
- exhausted  out  1  one-cycle pulse: search ended without ticket

Behaviour:
- Reset (async, active-high) clears all state: outputs midstate=0, data2=0, start_mining=0, tx_valid=0, tx_data=0, exhausted=0; byte counter=0, pending=0, state IDLE.
- Receive path (independent of FSM):
  - 352-bit shadow shift buffer plus a 6-bit byte counter 0..43.
  - Byte k lands at bits [8k+7:8k] of {data2,midstate}: bytes 0-31 are midstate, LSB byte first; bytes 32-43 are data2.
  - Gap timer resets on every rx_valid. When it reaches RX_TIMEOUT with counter≠0, counter←0 and the partial packet is dropped.
  - On the 44th byte (counter==43 & rx_valid): counter←0 and pending←1.
- FSM states: IDLE, LOAD, START, GUARD, MINING, REPORT.
  - IDLE: pending → LOAD.
  - LOAD (1 cycle): shadow → midstate/data2 outputs; pending←0; → START.
  - START (1 cycle): start_mining=1; guard counter←0; → GUARD.
  - GUARD: count START_GUARD cycles, then → MINING. If pending → LOAD (restart).
  - MINING, first matching rule wins:
    - pending → LOAD (abort; a ticket in the same cycle is discarded).
    - else got_ticket → capture golden_nonce, byte index←0, → REPORT.
    - else !miner_busy → exhausted=1 for 1 cycle, → IDLE.
  - REPORT:
    - tx_valid=1 with captured nonce bytes, LSB first (bytes 0..3).
    - Index advances only on tx_valid&tx_ready. tx_data is stable while tx_valid=1 and !tx_ready.
    - After byte 3 is accepted, tx_valid←0; then pending → LOAD, else → IDLE.
    - Packet completion during REPORT only sets pending; the report is never truncated.
- Latency:
  - Last rx byte sampled at edge E.
  - LOAD during E..E+1; midstate/data2 valid after E+1.
  - start_mining high E+1..E+2, so the core samples start at E+2 with midstate already stable.
- A packet completing in the same cycle as the gap timeout is accepted; the timeout is ignored because the gap timer reset on that rx_valid.
- Reset mid-REPORT: tx_valid drops immediately (async); the partial nonce is not resent.

Test Plan:
- Reset, then send 44 bytes 0x00..0x2B back-to-back → midstate[7:0]=0x00, midstate[255:248]=0x1F, data2[95:88]=0x2B; start_mining exactly 1 cycle, 2 edges after byte 44.
- Mining, then got_ticket=1 with golden_nonce=32'h80001234, tx_ready=1 → tx bytes 34,12,00,80 on 4 consecutive cycles; then IDLE.
- Same as above with tx_ready toggling 1-0-0-1 → tx_data held while stalled; the byte sequence is unchanged.
- Mining, miner_busy falls with got_ticket=0 → exhausted pulses 1 cycle; no tx_valid.
- Send 20 bytes, idle RX_TIMEOUT cycles, then send a full 44-byte packet → outputs reflect only the second packet; one start pulse.
- During MINING, a second packet completes → new midstate loaded and a second start_mining issued. Packet completing during REPORT → all 4 nonce bytes are sent first, then LOAD/START; assert rst mid-packet → counter=0 and outputs=0.
